// File: rtl/fitness_accumulator_if.sv
// Diff-stage handshake bus: one mismatch count per vector, valid/ready flow control.
interface fitness_accumulator_if #(
    parameter int DiffWidth = 3
);
    logic                 DiffValid;
    logic [DiffWidth-1:0] DiffIn;
    logic                 DiffReady;

    modport master (output DiffValid, output DiffIn, input DiffReady);
    modport slave  (input DiffValid, input DiffIn, output DiffReady);
endinterface

// File: rtl/fitness_accumulator.sv
// Sums Diff-stage mismatch counts over Samples vectors per individual and tracks
// the lowest-scoring individual across one Population-sized generation.
//
// state | meaning
// IDLE  | waiting for Start; results of the last generation held
// ACCUM | accepting mismatch counts for the current individual
// EMIT  | one-cycle Fitness/Index presentation, best-so-far update
// DONE  | one-cycle end-of-generation pulse
module fitness_accumulator #(
    parameter int Width      = 8,
    parameter int DiffWidth  = $clog2(Width),
    parameter int Samples    = 16,
    parameter int Population = 32,
    localparam int SumWidth  = DiffWidth + $clog2(Samples) + 1,
    localparam int IdxWidth  = (Population > 1) ? $clog2(Population) : 1
) (
    input  logic                   Clk,
    input  logic                   Rst_n,
    input  logic                   Start,
    fitness_accumulator_if.slave   diff,
    output logic [SumWidth-1:0]    Fitness,
    output logic                   FitnessValid,
    output logic [IdxWidth-1:0]    Index,
    output logic [SumWidth-1:0]    BestFitness,
    output logic [IdxWidth-1:0]    BestIndex,
    output logic                   Busy,
    output logic                   Done
);

    localparam int SampWidth = (Samples > 1) ? $clog2(Samples) : 1;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ACCUM = 2'd1;
    localparam logic [1:0] EMIT  = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    localparam logic [SampWidth-1:0] SAMP_LAST = SampWidth'(Samples - 1);
    localparam logic [IdxWidth-1:0]  IDX_LAST  = IdxWidth'(Population - 1);

    logic [1:0]           state_q,    state_d;
    logic [SumWidth-1:0]  sum_q,      sum_d;
    logic [SampWidth-1:0] sample_q,   sample_d;
    logic [IdxWidth-1:0]  ind_q,      ind_d;
    logic [SumWidth-1:0]  fitness_q,  fitness_d;
    logic [IdxWidth-1:0]  index_q,    index_d;
    logic [SumWidth-1:0]  best_fit_q, best_fit_d;
    logic [IdxWidth-1:0]  best_idx_q, best_idx_d;
    logic [SumWidth-1:0]  sum_add;

    // Next-state and datapath: accumulate in ACCUM, publish and compare in EMIT.
    always_comb begin
        state_d    = state_q;
        sum_d      = sum_q;
        sample_d   = sample_q;
        ind_d      = ind_q;
        fitness_d  = fitness_q;
        index_d    = index_q;
        best_fit_d = best_fit_q;
        best_idx_d = best_idx_q;
        sum_add    = sum_q + SumWidth'(diff.DiffIn);

        case (state_q)
            IDLE: begin
                if (Start) begin
                    state_d    = ACCUM;
                    sum_d      = '0;
                    sample_d   = '0;
                    ind_d      = '0;
                    best_fit_d = '1;
                    best_idx_d = '0;
                end
            end
            ACCUM: begin
                if (diff.DiffValid) begin
                    sum_d = sum_add;
                    if (sample_q == SAMP_LAST) begin
                        // Latch the result now so it is stable for the whole EMIT cycle.
                        fitness_d = sum_add;
                        index_d   = ind_q;
                        state_d   = EMIT;
                    end else begin
                        sample_d = sample_q + 1'b1;
                    end
                end
            end
            EMIT: begin
                // Strict compare: on a tie the earlier individual keeps the title.
                if (fitness_q < best_fit_q) begin
                    best_fit_d = fitness_q;
                    best_idx_d = index_q;
                end
                sum_d    = '0;
                sample_d = '0;
                ind_d    = ind_q + 1'b1;
                state_d  = (ind_q == IDX_LAST) ? DONE : ACCUM;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            state_q    <= IDLE;
            sum_q      <= '0;
            sample_q   <= '0;
            ind_q      <= '0;
            fitness_q  <= '0;
            index_q    <= '0;
            best_fit_q <= '1;
            best_idx_q <= '0;
        end else begin
            state_q    <= state_d;
            sum_q      <= sum_d;
            sample_q   <= sample_d;
            ind_q      <= ind_d;
            fitness_q  <= fitness_d;
            index_q    <= index_d;
            best_fit_q <= best_fit_d;
            best_idx_q <= best_idx_d;
        end
    end

    assign diff.DiffReady = (state_q == ACCUM);
    assign FitnessValid   = (state_q == EMIT);
    assign Done           = (state_q == DONE);
    assign Busy           = (state_q != IDLE);
    assign Fitness        = fitness_q;
    assign Index          = index_q;
    assign BestFitness    = best_fit_q;
    assign BestIndex      = best_idx_q;

endmodule
